// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-way round-robin arbiter with a registered one-hot grant.
//
// Shares one downstream resource between four requesters. The grant is held
// while its owner keeps requesting. Once the owner has held it for MAX_HOLD
// consecutive cycles and someone else is waiting, the grant rotates.
//
// Parameters:
//   MAX_HOLD   consecutive granted cycles before forced rotation (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   request vector, bit i = requester i
//   gnt[3:0]   registered one-hot grant, zero when idle
//   gnt_idx    binary index of the granted requester, 0 when idle
//   gnt_valid  high whenever a grant is outstanding
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] idx_reg, idx_next;
  logic       valid_reg, valid_next;
  logic [1:0] last_reg, last_next;
  logic [3:0] hold_reg, hold_next;

  // Requests rotated into scan order. Position gi holds requester
  // (last+1+gi) mod 4, so position 0 has the highest priority. In BUSY,
  // last is the current owner, so the owner is always scanned last.
  logic [1:0] scan_idx [4];
  logic [3:0] scan_req;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      localparam logic [1:0] OFF = 2'(gi + 1);
      assign scan_idx[gi] = last_reg + OFF;
      assign scan_req[gi] = req[scan_idx[gi]];
    end
  endgenerate

  // The lowest set position in scan order wins.
  logic [1:0] win_off;
  logic [1:0] winner;
  logic [3:0] winner_oh;

  always_comb begin
    win_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (scan_req[i]) begin
        win_off = 2'(i);
      end
    end
  end

  assign winner    = scan_idx[win_off];
  assign winner_oh = 4'b0001 << winner;

  logic any_req;
  logic owner_req;
  logic others_req;

  assign any_req    = |req;
  assign owner_req  = req[last_reg];
  assign others_req = |(req & ~gnt_reg);

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;

    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = BUSY;
          gnt_next   = winner_oh;
          idx_next   = winner;
          valid_next = 1'b1;
          last_next  = winner;
          hold_next  = 4'd1;
        end else begin
          gnt_next   = 4'b0000;
          idx_next   = 2'd0;
          valid_next = 1'b0;
          hold_next  = 4'd0;
        end
      end

      BUSY: begin
        if (!owner_req) begin
          // Owner released. Hand straight over to the next requester,
          // with no idle cycle in between, if one is waiting.
          if (any_req) begin
            gnt_next   = winner_oh;
            idx_next   = winner;
            last_next  = winner;
            hold_next  = 4'd1;
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            idx_next   = 2'd0;
            valid_next = 1'b0;
            hold_next  = 4'd0;
          end
        end else if ((hold_reg == MAX_HOLD_C) && others_req) begin
          // Hold limit reached with a waiter present. The scan starts just
          // after the owner, so the winner is never the owner here.
          gnt_next  = winner_oh;
          idx_next  = winner;
          last_next = winner;
          hold_next = 4'd1;
        end else begin
          // Keep the grant. The counter saturates so that a lone owner
          // can hold the grant indefinitely.
          hold_next = (hold_reg >= MAX_HOLD_C) ? MAX_HOLD_C : hold_reg + 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      idx_reg   <= 2'd0;
      valid_reg <= 1'b0;
      last_reg  <= 2'd3;
      hold_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = valid_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4 -- testbench for rr_arbiter4.
//
// Three arbiters, with MAX_HOLD = 8, 3 and 1, see the same req and rst.
// Every cycle, each arbiter is compared against a behavioural model.
// A table of scenarios with known grant sequences is checked first. Next
// comes a lone-owner sequence, and then randomized traffic.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_a   [3];
  logic [1:0] idx_a   [3];
  logic       valid_a [3];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a[0]), .gnt_idx(idx_a[0]), .gnt_valid(valid_a[0])
  );
  rr_arbiter4 #(.MAX_HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a[1]), .gnt_idx(idx_a[1]), .gnt_valid(valid_a[1])
  );
  rr_arbiter4 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt_a[2]), .gnt_idx(idx_a[2]), .gnt_valid(valid_a[2])
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: owner is -1 when idle.
  int maxh    [3] = '{8, 3, 1};
  int m_owner [3];
  int m_last  [3];
  int m_hold  [3];

  // First active requester after 'last', wrapping upward.
  function automatic int pick(input int last, input logic [3:0] q);
    for (int k = 1; k <= 4; k++) begin
      if (q[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic void grant_to(input int k, input int w);
    m_owner[k] = w;
    m_last[k]  = w;
    m_hold[k]  = 1;
  endfunction

  function automatic void model_step(input int k, input logic r, input logic [3:0] q);
    if (r) begin
      m_owner[k] = -1;
      m_last[k]  = 3;
      m_hold[k]  = 0;
    end else if (m_owner[k] < 0) begin
      if (q != 4'b0000) grant_to(k, pick(m_last[k], q));
    end else if (!q[m_owner[k]]) begin
      if (q != 4'b0000) grant_to(k, pick(m_last[k], q));
      else m_owner[k] = -1;
    end else if (m_hold[k] == maxh[k] && (q & ~(4'b0001 << m_owner[k])) != 4'b0000) begin
      grant_to(k, pick(m_last[k], q));
    end else if (m_hold[k] < maxh[k]) begin
      m_hold[k] = m_hold[k] + 1;
    end
  endfunction

  task automatic check_model();
    logic [3:0] eg;
    logic [1:0] ei;
    logic       ev;
    for (int k = 0; k < 3; k++) begin
      eg = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
      ei = (m_owner[k] < 0) ? 2'd0 : 2'(m_owner[k]);
      ev = (m_owner[k] >= 0);
      n_vec++;
      if (gnt_a[k] !== eg || idx_a[k] !== ei || valid_a[k] !== ev) begin
        n_bad++;
        $display("FAIL model_mh%0d t=%0t req=%b: got gnt=%b idx=%0d valid=%b, required gnt=%b idx=%0d valid=%b",
                 maxh[k], $time, req, gnt_a[k], idx_a[k], valid_a[k], eg, ei, ev);
      end
    end
  endtask

  // Apply one cycle of inputs, then advance the model and compare just
  // after the edge.
  task automatic step(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) model_step(k, r, q);
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] exp8;   // expected grant with MAX_HOLD=8
    logic [3:0] exp3;   // expected grant with MAX_HOLD=3
  } vec_t;

  vec_t vecs [$];

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1;
      m_last[k]  = 3;
      m_hold[k]  = 0;
    end

    // Reset, with every requester asserted.
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000});
    // Round robin: drop the owner's bit after each grant.
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 4'b0001});
    vecs.push_back('{1'b0, 4'b1110, 4'b0010, 4'b0010});
    vecs.push_back('{1'b0, 4'b1101, 4'b0100, 4'b0100});
    vecs.push_back('{1'b0, 4'b1011, 4'b1000, 4'b1000});
    vecs.push_back('{1'b0, 4'b0111, 4'b0001, 4'b0001});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000});
    // Hold limit: reset so requester 0 is first, then hold req=0011.
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0001});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0001});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0001});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0010});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0010});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0010});
    vecs.push_back('{1'b0, 4'b0011, 4'b0001, 4'b0001});
    // Wrap and idle: grant 3, go idle, then 1001 goes to requester 0.
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b1000, 4'b1000, 4'b1000});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b1001, 4'b0001, 4'b0001});
    // Mid-grant reset: after reset, the scan restarts at requester 0.
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 4'b0010});
    vecs.push_back('{1'b1, 4'b0110, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 4'b0110, 4'b0010, 4'b0010});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      $display("vec %0d rst=%b req=%b gnt8=%b gnt3=%b gnt1=%b", i, vecs[i].rst,
               vecs[i].req, gnt_a[0], gnt_a[1], gnt_a[2]);
      n_vec++;
      if (gnt_a[0] !== vecs[i].exp8) begin
        n_bad++;
        $display("FAIL table_mh8[%0d]: got gnt=%b, required %b", i, gnt_a[0], vecs[i].exp8);
      end
      n_vec++;
      if (gnt_a[1] !== vecs[i].exp3) begin
        n_bad++;
        $display("FAIL table_mh3[%0d]: got gnt=%b, required %b", i, gnt_a[1], vecs[i].exp3);
      end
    end

    // Lone owner: requester 2 alone for 20 cycles, then release.
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b0100);
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (gnt_a[k] !== 4'b0100 || idx_a[k] !== 2'd2) begin
          n_bad++;
          $display("FAIL lone_owner_mh%0d cycle %0d: got gnt=%b idx=%0d, required gnt=0100 idx=2",
                   maxh[k], c, gnt_a[k], idx_a[k]);
        end
      end
    end
    $display("lone owner held 20 cycles, releasing");
    step(1'b0, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (gnt_a[k] !== 4'b0000 || valid_a[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL lone_release_mh%0d: got gnt=%b valid=%b, required gnt=0000 valid=0",
                 maxh[k], gnt_a[k], valid_a[k]);
      end
    end

    // Randomized traffic. Requests are often kept steady so that the hold
    // limits are exercised, and there is an occasional reset.
    begin
      logic [3:0] q;
      logic       r;
      q = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
        r = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
        step(r, q);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
